// File: rtl/mode_counter_pkg.sv
// ============================================================================
// Module   : mode_counter_pkg
// Brief    : Shared mode and direction encodings for mode_counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mode_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Clock-enable divider; one tick per prescale+1 enabled cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_pre,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    // A lowered prescale can leave pre_cnt above it; it then runs up and wraps
    // through zero before matching again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clr_pre) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
// ============================================================================
// Module   : mode_counter
// Brief    : Up/down counter with prescaler and wrap/saturate/one-shot modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tick;
    logic             clr_pre;
    logic             at_bound;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             done_nxt;

    assign clr_pre = clr | load;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr_pre  (clr_pre),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Up uses >= so a load above limit still terminates on the next tick.
    assign at_bound = (dir == DIR_DOWN) ? (count == '0) : (count >= limit);

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;
        done_nxt  = done;
        if (clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            done_nxt  = 1'b0;
        end else if (load) begin
            count_nxt = load_val;
            done_nxt  = 1'b0;
        end else if (tick && !done) begin
            if (at_bound) begin
                tc_nxt = 1'b1;
                case (mode)
                    MODE_SAT: begin
                        count_nxt = count;
                    end
                    MODE_ONESHOT: begin
                        done_nxt = 1'b1;
                    end
                    default: begin
                        count_nxt = (dir == DIR_DOWN) ? limit : '0;
                        ovf_nxt   = 1'b1;
                    end
                endcase
            end else begin
                count_nxt = (dir == DIR_DOWN) ? (count - ONE) : (count + ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
            done  <= done_nxt;
        end
    end

endmodule

`default_nettype wire
